rob_commit: RTL and testbench
=============================

// Module: rob_commit
// PURPOSE
//  Reorder buffer for the Tomasulo core: the in-order writer into the register file's ROB write port.
//  - Allocates one entry and one tag per issued instruction; the decoder writes that tag into the regfile tag table.
//  - Captures results broadcast on the CDB.
//  - Retires the oldest ready entry each cycle as {enWrite, namew, dataw, tagw}.
// PARAMETERS
//  DATA_WIDTH  32  result / register data width
//  REG_WIDTH   5   architectural register index width
//  ROB_DEPTH   8   entry count; power of two, >= 2
//  TAG_WIDTH   4   tag width; must hold ROB_DEPTH-1 and TAG_FREE
//  TAG_FREE    15  "no producer" tag value, never allocated
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  alloc_req    in   1           decoder issues one instruction this cycle
//  alloc_reg    in   REG_WIDTH   destination register of the issued instruction
//  alloc_ready  out  1           entry available (count < ROB_DEPTH), combinational
//  alloc_tag    out  TAG_WIDTH   tag granted on this cycle's alloc, = tail index zero-extended, combinational
//  cdb_valid    in   1           CDB broadcast valid
//  cdb_tag      in   TAG_WIDTH   tag of the broadcast result
//  cdb_data     in   DATA_WIDTH  broadcast result
//  commit_en    out  1           retire pulse -> regfile enWrite, registered
//  commit_name  out  REG_WIDTH   -> regfile namew, registered
//  commit_data  out  DATA_WIDTH  -> regfile dataw, registered
//  commit_tag   out  TAG_WIDTH   -> regfile tagw (retiring entry index), registered
//  count        out  clog2(ROB_DEPTH)+1  occupied entries, registered
// BEHAVIOUR
//  - Entry state: valid, ready, reg, data. Pointers head/tail are log2(ROB_DEPTH) bits and wrap modulo ROB_DEPTH.
//  - Reset (asynchronous, any time, including mid-operation):
//    - all valid/ready cleared; head = tail = count = 0;
//    - commit_en/commit_name/commit_data/commit_tag = 0.
//  - Alloc fires when alloc_req && alloc_ready:
//    - entry[tail] <= {valid=1, ready=0, reg=alloc_reg}; tail <= tail+1.
//    - alloc_req while !alloc_ready is ignored; the decoder must stall.
//  - CDB capture fires when cdb_valid, cdb_tag < ROB_DEPTH, and entry[cdb_tag].valid && !ready:
//    - entry.data <= cdb_data; entry.ready <= 1.
//    - Any other broadcast is ignored: TAG_FREE, out-of-range, invalid entry, or already ready.
//  - Commit, evaluated every cycle:
//    - If entry[head].valid && entry[head].ready:
//      commit_en <= 1; commit_name/data <= entry fields; commit_tag <= head;
//      entry[head].valid <= 0; head <= head+1.
//    - Otherwise commit_en <= 0 and the other commit_* outputs hold their values.
//    - At most one retire per cycle. reg = 0 still retires; the regfile discards the write.
//  - Latency: alloc at edge E, CDB at edge E+k (k >= 1, entry at head) -> commit_en high for one cycle after edge E+k+1.
//  - Full: alloc_ready = (count < ROB_DEPTH) and does not depend on same-cycle commit.
//    A full ROB that retires this cycle accepts an alloc next cycle.
//  - Empty: count = 0, no commit; a CDB broadcast with no valid entry changes nothing.
//  - Simultaneous alloc and commit: count unchanged. Alloc into the slot head frees this cycle cannot occur (full blocks alloc).
//  - Simultaneous alloc and CDB on the same index cannot occur for valid entries; alloc wins if it does.
//  - count <= count + alloc_fire - commit_fire.
// CONFIGURATION
//  ROB_CDB_BYPASS_EN defined:
//   - If entry[head].valid && !ready and the CDB capture condition holds with cdb_tag == head,
//     retire this cycle using commit_data <= cdb_data.
//   - Saves one cycle of latency.
//  ROB_CDB_BYPASS_EN undefined: retire only from stored ready entries, per the latency above.
// TESTING
//  - Reset then alloc reg 3 (tag 0), CDB tag 0 data 0xDEADBEEF -> after 2 edges: commit_en=1, name=3, data=0xDEADBEEF, tag=0; count 1->0.
//  - Alloc regs 1,2,3 (tags 0,1,2); CDB tags 2,1,0 on successive cycles -> retire order tags 0,1,2 on 3 consecutive cycles.
//  - Alloc 8 entries -> alloc_ready=0, count=8; a 9th alloc_req is ignored and tail stays put.
//    CDB tag 0 -> one retire -> alloc_ready=1; next alloc_tag=0 (wrap).
//  - CDB with tag 15 (TAG_FREE), tag to an empty slot, and a repeat CDB to a ready entry -> no state change, stored data unchanged.
//  - Assert rst while 5 entries are pending and commit_en=1 -> immediately commit_en=0 and count=0.
//    After release, the first alloc_tag=0.
//  - Bypass: alloc reg 7 (tag 0), CDB tag 0 data 0x5 in the next cycle.
//    ROB_CDB_BYPASS_EN defined -> commit_en after 1 edge; undefined -> after 2 edges.

Source files
------------

// File: rtl/rob_commit_if.sv
// rob_commit_if: decoder allocation, CDB broadcast and register-file retire
// signals of the reorder buffer, bundled for the rob_commit port list.
// The ROB itself connects through the slave modport; the decoder/regfile side
// uses master.
interface rob_commit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int TAG_WIDTH  = 4,
    parameter int ROB_DEPTH  = 8
);
    localparam int CNT_WIDTH = $clog2(ROB_DEPTH) + 1;

    // Allocation handshake with the decoder
    logic                  alloc_req;
    logic [REG_WIDTH-1:0]  alloc_reg;
    logic                  alloc_ready;
    logic [TAG_WIDTH-1:0]  alloc_tag;

    // Common data bus broadcast
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;

    // In-order retire into the register file ROB write port
    logic                  commit_en;
    logic [REG_WIDTH-1:0]  commit_name;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [TAG_WIDTH-1:0]  commit_tag;
    logic [CNT_WIDTH-1:0]  count;

    modport slave (
        input  alloc_req, alloc_reg, cdb_valid, cdb_tag, cdb_data,
        output alloc_ready, alloc_tag, commit_en, commit_name, commit_data,
               commit_tag, count
    );

    modport master (
        output alloc_req, alloc_reg, cdb_valid, cdb_tag, cdb_data,
        input  alloc_ready, alloc_tag, commit_en, commit_name, commit_data,
               commit_tag, count
    );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer of the Tomasulo core. Allocates one entry/tag per
// issued instruction, captures CDB results, and retires the oldest ready entry
// (at most one per cycle) into the register file ROB write port.
// Optional feature macro ROB_CDB_BYPASS_EN: a CDB result for the head entry
// retires in the same cycle it is broadcast, saving one cycle of latency.
module rob_commit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int ROB_DEPTH  = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int TAG_FREE   = 15
) (
    input  logic        clk,
    input  logic        rst,
    rob_commit_if.slave bus
);
    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TAG_WIDTH:0]   DEPTH_EXT = (TAG_WIDTH + 1)'(ROB_DEPTH);
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(ROB_DEPTH);
    localparam logic [TAG_WIDTH-1:0] FREE_TAG  = TAG_WIDTH'(TAG_FREE);

    // Entry state: control bits are reset, payload is not
    logic [ROB_DEPTH-1:0]  r_valid;
    logic [ROB_DEPTH-1:0]  r_ready;
    logic [REG_WIDTH-1:0]  r_reg  [ROB_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [ROB_DEPTH];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  r_commit_en;
    logic [REG_WIDTH-1:0]  r_commit_name;
    logic [DATA_WIDTH-1:0] r_commit_data;
    logic [TAG_WIDTH-1:0]  r_commit_tag;

    logic                  w_alloc_ready;
    logic                  w_alloc_fire;
    logic [PTR_W-1:0]      w_cdb_idx;
    logic                  w_cdb_hit;
    logic                  w_commit_fire;
    logic [DATA_WIDTH-1:0] w_commit_data;

    // Full check looks only at the registered count, never at this cycle's retire
    assign w_alloc_ready = (r_count < DEPTH_CNT);
    assign w_alloc_fire  = bus.alloc_req && w_alloc_ready;

    // A broadcast only lands on an in-range, allocated, still-waiting entry;
    // TAG_FREE and out-of-range tags must not alias onto a low index
    assign w_cdb_idx = bus.cdb_tag[PTR_W-1:0];
    assign w_cdb_hit = bus.cdb_valid
                    && (bus.cdb_tag != FREE_TAG)
                    && ({1'b0, bus.cdb_tag} < DEPTH_EXT)
                    && r_valid[w_cdb_idx] && !r_ready[w_cdb_idx];

    // Retire decision for the head entry, optionally bypassing the CDB
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_commit_fire = r_valid[r_head] && r_ready[r_head];
        w_commit_data = r_data[r_head];
`ifdef ROB_CDB_BYPASS_EN
        if (r_valid[r_head] && !r_ready[r_head] && w_cdb_hit && (w_cdb_idx == r_head)) begin
            w_commit_fire = 1'b1;
            w_commit_data = bus.cdb_data;
        end
`else
`endif
    end

    // Entry control bits, pointers and occupancy
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_ready[w_cdb_idx] <= 1'b1;
            end
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // Placed last so an allocation wins any same-index CDB write
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_commit_fire);
        end
    end

    // Entry payload storage
    // NOTE: payload arrays are not reset; valid/ready gate every use, so resetting them would only cost flops.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_reg[r_tail] <= bus.alloc_reg;
        end
        if (w_cdb_hit) begin
            r_data[w_cdb_idx] <= bus.cdb_data;
        end
    end

    // Registered retire port; fields hold their last value between retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_en   <= 1'b0;
            r_commit_name <= '0;
            r_commit_data <= '0;
            r_commit_tag  <= '0;
        end else begin
            r_commit_en <= w_commit_fire;
            if (w_commit_fire) begin
                r_commit_name <= r_reg[r_head];
                r_commit_data <= w_commit_data;
                r_commit_tag  <= TAG_WIDTH'(r_head);
            end
        end
    end

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.alloc_tag   = TAG_WIDTH'(r_tail);
    assign bus.commit_en   = r_commit_en;
    assign bus.commit_name = r_commit_name;
    assign bus.commit_data = r_commit_data;
    assign bus.commit_tag  = r_commit_tag;
    assign bus.count       = r_count;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed bench for rob_commit. Expected retires are pushed to
// a scoreboard queue at allocation time and compared in order by a monitor
// whenever commit_en is seen. Cycle-exact latency, full/empty, ignored CDB,
// wrap and mid-operation reset cases are checked from the main sequence.
module tb_rob_commit;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 4;
    localparam int DEPTH = 8;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [RW-1:0] name;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    rob_commit_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .TAG_WIDTH(TW), .ROB_DEPTH(DEPTH)) bus ();

    rob_commit #(
        .DATA_WIDTH(DW), .REG_WIDTH(RW), .ROB_DEPTH(DEPTH), .TAG_WIDTH(TW), .TAG_FREE(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every retire must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.commit_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 64'(bus.commit_tag), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_name", 64'(bus.commit_name), 64'(e.name));
                check("sb_data", 64'(bus.commit_data), 64'(e.data));
                check("sb_tag",  64'(bus.commit_tag),  64'(e.tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        bus.alloc_req = 1'b0;
        bus.cdb_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One allocation edge; the planned result is recorded for the scoreboard
    task automatic alloc(input logic [RW-1:0] r, input logic [DW-1:0] d, input logic [TW-1:0] t);
        exp_t e;
        check("alloc_tag", 64'(bus.alloc_tag), 64'(t));
        bus.alloc_req = 1'b1;
        bus.alloc_reg = r;
        e.name = r; e.data = d; e.tag = t;
        sb.push_back(e);
        tick();
        bus.alloc_req = 1'b0;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        bus.alloc_req = 1'b0;
        bus.alloc_reg = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_ready", 64'(bus.alloc_ready), 64'd1);
        check("rst_tag",   64'(bus.alloc_tag), 64'd0);
        check("rst_en",    64'(bus.commit_en), 64'd0);
        check("rst_name",  64'(bus.commit_name), 64'd0);
        check("rst_data",  64'(bus.commit_data), 64'd0);
        check("rst_ctag",  64'(bus.commit_tag), 64'd0);

        // Single instruction latency
        alloc(5'd3, 32'hDEADBEEF, 4'd0);
        check("t1_count_alloc", 64'(bus.count), 64'd1);
        cdb(4'd0, 32'hDEADBEEF);
        check("t1_en_e1",    64'(bus.commit_en), 64'(BYP));
        check("t1_count_e1", 64'(bus.count), BYP ? 64'd0 : 64'd1);
        tick();
        check("t1_en_e2",    64'(bus.commit_en), 64'(!BYP));
        check("t1_count_e2", 64'(bus.count), 64'd0);
        check("t1_name", 64'(bus.commit_name), 64'd3);
        check("t1_data", 64'(bus.commit_data), 64'hDEADBEEF);
        check("t1_ctag", 64'(bus.commit_tag), 64'd0);
        drain("t1_drain");

        // Out-of-order completion, in-order retire
        do_reset();
        alloc(5'd1, 32'h1111_0000, 4'd0);
        alloc(5'd2, 32'h2222_0001, 4'd1);
        alloc(5'd3, 32'h3333_0002, 4'd2);
        cdb(4'd2, 32'h3333_0002);
        check("t2_hold_en", 64'(bus.commit_en), 64'd0);
        cdb(4'd1, 32'h2222_0001);
        check("t2_hold_en2", 64'(bus.commit_en), 64'd0);
        cdb(4'd0, 32'h1111_0000);
        if (!BYP) begin
            check("t2_pre_en", 64'(bus.commit_en), 64'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("t2_seq_en",  64'(bus.commit_en), 64'd1);
            check("t2_seq_tag", 64'(bus.commit_tag), 64'(i));
            if (i < 2) tick();
        end
        tick();
        check("t2_done_en",    64'(bus.commit_en), 64'd0);
        check("t2_done_count", 64'(bus.count), 64'd0);
        drain("t2_drain");

        // Full ROB, ignored extra alloc, retire frees a slot, tail wraps
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(RW'(i + 8), DW'(32'h100 + i), TW'(i));
        check("t3_full_count", 64'(bus.count), 64'd8);
        check("t3_full_ready", 64'(bus.alloc_ready), 64'd0);
        bus.alloc_req = 1'b1;
        bus.alloc_reg = 5'd30;
        tick();
        bus.alloc_req = 1'b0;
        check("t3_ignored_count", 64'(bus.count), 64'd8);
        check("t3_ignored_tail",  64'(bus.alloc_tag), 64'd0);
        cdb(4'd0, 32'h100);
        if (!BYP) begin
            check("t3_still_full", 64'(bus.alloc_ready), 64'd0);
            tick();
        end
        check("t3_retire_en",    64'(bus.commit_en), 64'd1);
        check("t3_retire_count", 64'(bus.count), 64'd7);
        check("t3_ready_again",  64'(bus.alloc_ready), 64'd1);
        alloc(5'd9, 32'h999, 4'd0);
        check("t3_refill_count", 64'(bus.count), 64'd8);

        // Ignored broadcasts leave state and stored data unchanged
        do_reset();
        alloc(5'd5, 32'h50, 4'd0);
        alloc(5'd6, 32'h61, 4'd1);
        cdb(4'd15, 32'hBAD0_000F);
        cdb(4'd9,  32'hBAD0_0009);
        cdb(4'd3,  32'hBAD0_0003);
        check("t4_ign_count", 64'(bus.count), 64'd2);
        check("t4_ign_en",    64'(bus.commit_en), 64'd0);
        cdb(4'd1, 32'h61);
        cdb(4'd1, 32'hBAD0_0001);
        check("t4_rep_count", 64'(bus.count), 64'd2);
        check("t4_rep_en",    64'(bus.commit_en), 64'd0);
        cdb(4'd0, 32'h50);
        drain("t4_drain");
        check("t4_end_count", 64'(bus.count), 64'd0);

        // Reset mid-operation while a retire is being presented
        do_reset();
        for (int i = 0; i < 6; i++) alloc(RW'(i + 1), DW'(32'hA0 + i), TW'(i));
        cdb(4'd0, 32'hA0);
        if (!BYP) tick();
        check("t5_pre_en",    64'(bus.commit_en), 64'd1);
        check("t5_pre_count", 64'(bus.count), 64'd5);
        rst = 1'b1;
        sb.delete();
        #1;
        check("t5_rst_en",    64'(bus.commit_en), 64'd0);
        check("t5_rst_count", 64'(bus.count), 64'd0);
        tick();
        rst = 1'b0;
        check("t5_post_tag",   64'(bus.alloc_tag), 64'd0);
        check("t5_post_ready", 64'(bus.alloc_ready), 64'd1);
        alloc(5'd2, 32'hC0FFEE, 4'd0);
        cdb(4'd0, 32'hC0FFEE);
        drain("t5_drain");

        // CDB-to-retire bypass latency
        do_reset();
        alloc(5'd7, 32'h5, 4'd0);
        cdb(4'd0, 32'h5);
        check("t6_en_1edge", 64'(bus.commit_en), 64'(BYP));
        tick();
        check("t6_en_2edge", 64'(bus.commit_en), 64'(!BYP));
        check("t6_data", 64'(bus.commit_data), 64'h5);
        drain("t6_drain");
        tick();
        check("t6_idle_en", 64'(bus.commit_en), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
